// File: rtl/rtu2_code_expander_if.sv
// Handshake bundle for the code expander: code-word input stream, pattern output stream,
// occupancy and illegal-code counter.
interface rtu2_code_expander_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ERR_W = 8
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic             in_vld;
  logic             in_rdy;
  logic             in_v;
  logic [2:0]       in_code;
  logic             out_vld;
  logic             out_rdy;
  logic [5:0]       out_pat;
  logic             out_err;
  logic [LVL_W-1:0] level;
  logic             err_clr;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output in_vld, in_v, in_code, out_rdy, err_clr,
    input  in_rdy, out_vld, out_pat, out_err, level, err_cnt
  );

  modport slave (
    input  in_vld, in_v, in_code, out_rdy, err_clr,
    output in_rdy, out_vld, out_pat, out_err, level, err_cnt
  );
endinterface

// File: rtl/rtu2_code_expander.sv
// Expands {v, code} priority-code words into 6-bit patterns through a small FWFT FIFO,
// flagging illegal codes and counting them in a saturating counter.
module rtu2_code_expander #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ERR_W = 8
) (
  input logic               clk,
  input logic               rst,
  rtu2_code_expander_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  logic [6:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [ERR_W-1:0] err_cnt_q;

  logic       in_rdy;
  logic       out_vld;
  logic       push;
  logic       pop;
  logic [6:0] word;
  logic [6:0] head;

  // Word is stored as {err, pat}, expanded once at push time.
  always_comb begin
    word = 7'b0_000000;
    if (bus.in_v) begin
      case (bus.in_code)
        3'b000:  word = 7'b0_010000;
        3'b001:  word = 7'b0_001000;
        3'b011:  word = 7'b0_100000;
        3'b100:  word = 7'b0_000100;
        3'b110:  word = 7'b0_000001;
        default: word = 7'b1_000000;
      endcase
    end
  end

  assign in_rdy  = (level_q != LVL_FULL);
  assign out_vld = (level_q != '0);
  assign push    = bus.in_vld & in_rdy;
  assign pop     = out_vld & bus.out_rdy;
  assign head    = mem_q[rd_ptr_q];

  assign bus.in_rdy  = in_rdy;
  assign bus.out_vld = out_vld;
  assign bus.out_pat = out_vld ? head[5:0] : 6'b0;
  assign bus.out_err = out_vld & head[6];
  assign bus.level   = level_q;
  assign bus.err_cnt = err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 7'b0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= word;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Clear wins over the old count but not over an illegal word arriving the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (bus.err_clr) begin
      err_cnt_q <= (push && word[6]) ? ERR_W'(1) : '0;
    end else if (push && word[6] && (err_cnt_q != ERR_MAX)) begin
      err_cnt_q <= err_cnt_q + ERR_W'(1);
    end
  end
endmodule

// File: tb/tb_rtu2_code_expander.sv
// Self-checking bench for rtu2_code_expander: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_rtu2_code_expander;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [6:0] q [$];
  int         err_m = 0;

  rtu2_code_expander_if #(.DEPTH(DEPTH), .ERR_W(8)) bus ();
  rtu2_code_expander_if #(.DEPTH(DEPTH), .ERR_W(2)) bus2 ();

  rtu2_code_expander #(.DEPTH(DEPTH), .ERR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rtu2_code_expander #(.DEPTH(DEPTH), .ERR_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  always #5 clk = ~clk;

  // Canonical pattern is a single bit whose position depends on the code; -1 marks illegal.
  function automatic logic [6:0] expand_ref(bit v, bit [2:0] c);
    int pos [8];
    pos = '{4, 3, -1, 5, 2, -1, 0, -1};
    if (!v) return 7'b0;
    if (pos[c] < 0) return 7'b1_000000;
    return 7'(1 << pos[c]);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [6:0] h;
    h = (q.size() > 0) ? q[0] : 7'b0;
    chk("in_rdy", 32'(bus.in_rdy), 32'(q.size() < DEPTH));
    chk("out_vld", 32'(bus.out_vld), 32'(q.size() > 0));
    chk("out_pat", 32'(bus.out_pat), 32'(h[5:0]));
    chk("out_err", 32'(bus.out_err), 32'(h[6]));
  endtask

  // One clock cycle on the main instance; called at posedge+1.
  task automatic cycle(bit vld, bit v, bit [2:0] code, bit ordy, bit clr);
    bit         push;
    bit         pop;
    logic [6:0] w;
    bus.in_vld  = vld;
    bus.in_v    = v;
    bus.in_code = code;
    bus.out_rdy = ordy;
    bus.err_clr = clr;
    check_outputs();
    push = vld && (q.size() < DEPTH);
    pop  = ordy && (q.size() > 0);
    w    = expand_ref(v, code);
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(w);
    if (clr) err_m = (push && w[6]) ? 1 : 0;
    else if (push && w[6] && err_m < 255) err_m++;
    chk("level", 32'(bus.level), 32'(q.size()));
    chk("err_cnt", 32'(bus.err_cnt), 32'(err_m));
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
  endtask

  initial begin
    bit [2:0] legal_codes [5];
    legal_codes = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b110};
    {bus.in_vld, bus.in_v, bus.in_code, bus.out_rdy, bus.err_clr} = '0;
    {bus2.in_vld, bus2.in_v, bus2.in_code, bus2.out_rdy, bus2.err_clr} = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 0);
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: every legal code plus an invalid word, streamed with out_rdy=1
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, legal_codes[i], 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 3'b101, 1'b1, 1'b0);
    drain();

    // 2: fill past full with the sink stalled, then drain
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, legal_codes[i], 1'b0, 1'b0);
    chk("full_in_rdy", 32'(bus.in_rdy), 0);
    chk("full_level", 32'(bus.level), DEPTH);
    drain();
    chk("drained_level", 32'(bus.level), 0);

    // 3: illegal codes, then clear coinciding with an illegal push
    cycle(1'b1, 1'b1, 3'b010, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 3'b101, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 3'b111, 1'b1, 1'b0);
    chk("illegal_cnt3", 32'(bus.err_cnt), 3);
    cycle(1'b1, 1'b1, 3'b111, 1'b1, 1'b1);
    chk("clr_with_push", 32'(bus.err_cnt), 1);
    cycle(1'b0, 1'b0, 3'b000, 1'b1, 1'b1);
    chk("clr_alone", 32'(bus.err_cnt), 0);
    drain();

    // 4: saturation of a 2-bit counter on the second instance
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b0;
    bus.err_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus2.in_vld  = 1'b1;
      bus2.in_v    = 1'b1;
      bus2.in_code = 3'b010;
      bus2.out_rdy = 1'b1;
      @(posedge clk);
      #1;
      chk("sat_cnt", 32'(bus2.err_cnt), (i + 1 < 3) ? i + 1 : 3);
    end
    bus2.in_vld = 1'b0;

    // 5: steady level 2 with simultaneous push and pop across pointer wrap
    cycle(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 3'b001, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, legal_codes[$urandom_range(0, 4)], 1'b1, 1'b0);
      chk("steady_level", 32'(bus.level), 2);
    end
    drain();

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 19) == 0));
    end
    drain();

    // 6: asynchronous reset with three words buffered and a nonzero count
    cycle(1'b1, 1'b1, 3'b111, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 3'b011, 1'b0, 1'b0);
    chk("pre_rst_level", 32'(bus.level), 3);
    bus.in_vld = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    err_m = 0;
    chk("arst_out_vld", 32'(bus.out_vld), 0);
    chk("arst_level", 32'(bus.level), 0);
    chk("arst_in_rdy", 32'(bus.in_rdy), 1);
    chk("arst_err_cnt", 32'(bus.err_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b1, 1'b1, 3'b100, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 3'b001, 1'b0, 1'b0);
    chk("post_rst_head", 32'(bus.out_pat), 32'(6'b000100));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
